// File: rtl/dmux_rr_pkg.sv
// Shared definitions for the round-robin 1x4 demux dispatcher.
//   N_CH   : number of output channels
//   SEL_W  : width of a channel index
//   state_e: holding-register state (EMPTY / FULL)
//   onehot : channel index -> one-hot valid vector
package dmux_rr_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dmux_rr_pick.sv
// Combinational rotate-priority picker.
// Returns the first channel at or after start_i (wrapping) whose mask bit is set.
//   start_i : channel to try first
//   mask_i  : eligible channels
//   pick_o  : chosen channel (equals start_i when nothing is eligible)
//   found_o : at least one channel is eligible
module dmux_rr_pick
    import dmux_rr_pkg::*;
(
    input  logic [SEL_W-1:0] start_i,
    input  logic [N_CH-1:0]  mask_i,
    output logic [SEL_W-1:0] pick_o,
    output logic             found_o
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest offset back to offset 0 so the nearest eligible
    // channel is the last one written and therefore wins.
    always_comb begin
        pick_o  = start_i;
        found_o = 1'b0;
        idx     = start_i;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = start_i + SEL_W'(k);
            if (mask_i[idx]) begin
                pick_o  = idx;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmux_rr_dispatcher.sv
// Round-robin sequencing controller for a 1x4 demultiplexer.
// Accepts items over valid/ready into a one-entry holding register, assigns each
// to an enabled channel in round-robin order, steers the valid bit to that
// channel and counts deliveries per channel.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : producer item present
//   in_data    : producer item
//   in_ready   : item accepted this cycle
//   en_mask    : channels eligible for new assignments
//   out_valid  : one-hot (or zero) demuxed valid
//   out_data   : held item, shared by all channels
//   out_ready  : per-channel consumer ready
//   sel        : channel the held item is assigned to
//   cnt        : per-channel delivery counters, channel c at [c*CNT_W +: CNT_W]
module dmux_rr_dispatcher
    import dmux_rr_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    input  logic [N_CH-1:0]       en_mask,
    output logic [N_CH-1:0]       out_valid,
    output logic [W-1:0]          out_data,
    input  logic [N_CH-1:0]       out_ready,
    output logic [SEL_W-1:0]      sel,
    output logic [N_CH*CNT_W-1:0] cnt
);

    state_e           state_q, state_d;
    logic [W-1:0]     hold_q, hold_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    logic             deliver;
    logic             accept;
    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] pick;
    logic             found;

    assign deliver = (state_q == FULL) && out_ready[sel_q];

    // On a back-to-back cycle ptr_q is stale; the pointer it is about to take
    // (sel_q + 1) is used instead so throughput stays one item per cycle.
    assign start = deliver ? (sel_q + SEL_W'(1)) : ptr_q;

    dmux_rr_pick u_pick (
        .start_i (start),
        .mask_i  (en_mask),
        .pick_o  (pick),
        .found_o (found)
    );

    // found is equivalent to en_mask != 0; rst gates ready while held in reset.
    assign in_ready = !rst && ((state_q == EMPTY) || out_ready[sel_q]) && found;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        for (int c = 0; c < int'(N_CH); c++) begin
            cnt_d[c] = cnt_q[c];
        end

        if (deliver) begin
            cnt_d[sel_q] = cnt_q[sel_q] + CNT_W'(1);
            ptr_d        = sel_q + SEL_W'(1);
            state_d      = EMPTY;
        end

        if (accept) begin
            hold_d  = in_data;
            sel_d   = pick;
            state_d = FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            for (int c = 0; c < int'(N_CH); c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            for (int c = 0; c < int'(N_CH); c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign out_valid = (state_q == FULL) ? onehot(sel_q) : '0;
    assign out_data  = hold_q;
    assign sel       = sel_q;

    always_comb begin
        cnt = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            cnt[c*CNT_W +: CNT_W] = cnt_q[c];
        end
    end

endmodule

// File: tb/tb_dmux_rr_dispatcher.sv
module tb_dmux_rr_dispatcher;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic [3:0]       en_mask;
    logic [3:0]       out_valid;
    logic [W-1:0]     out_data;
    logic [3:0]       out_ready;
    logic [1:0]       sel;
    logic [4*CNT_W-1:0] cnt;

    dmux_rr_dispatcher #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] data;
        int           ch;
    } item_t;

    item_t sb[$];

    // Reference model state
    bit m_full;
    int m_sel;
    int m_ptr;
    int mcnt[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pick(input int start, input logic [3:0] en);
        for (int k = 0; k < 4; k++) begin
            if (en[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic int dut_cnt(input int c);
        return int'(cnt[c*CNT_W +: CNT_W]);
    endfunction

    // Monitor: compares what the DUT presents against the scoreboard.
    logic [3:0] exp_ov;
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                exp_ov = (sb.size() != 0) ? 4'(1 << sb[0].ch) : 4'b0000;
                check("out_valid", 64'(out_valid), 64'(exp_ov));
                for (int c = 0; c < 4; c++) begin
                    check("cnt", 64'(dut_cnt(c)), 64'(mcnt[c]));
                end
                if (sb.size() != 0 && out_ready[sb[0].ch]) begin
                    check("out_data", 64'(out_data), 64'(sb[0].data));
                    check("sel", 64'(sel), 64'(sb[0].ch));
                    mcnt[sb[0].ch] = (mcnt[sb[0].ch] + 1) % (1 << CNT_W);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle(input bit iv, input logic [W-1:0] d, input logic [3:0] en,
                         input logic [3:0] ordy);
        bit exp_rdy, deliver, accept;
        int start, pk;
        in_valid  = iv;
        in_data   = d;
        en_mask   = en;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = (!m_full || ordy[m_sel]) && (en != 4'b0000);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        deliver = m_full && ordy[m_sel];
        start   = deliver ? (m_sel + 1) % 4 : m_ptr;
        pk      = ref_pick(start, en);
        accept  = iv && exp_rdy;
        @(posedge clk);
        #1;
        if (deliver) m_ptr = (m_sel + 1) % 4;
        if (accept) begin
            sb.push_back('{d, pk});
            m_full = 1'b1;
            m_sel  = pk;
        end else if (deliver) begin
            m_full = 1'b0;
        end
    endtask

    task automatic reset_model();
        sb.delete();
        m_full = 1'b0;
        m_sel  = 0;
        m_ptr  = 0;
        for (int c = 0; c < 4; c++) mcnt[c] = 0;
    endtask

    // Asserts reset mid-stream and checks outputs clear before the next edge.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_cnt", 64'(cnt), 64'h0);
        check("rst_sel", 64'(sel), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int exp_b[4] = '{1, 3, 1, 3};
    logic [3:0] r_en, r_rdy;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        en_mask   = 4'hF;
        out_ready = 4'hF;
        reset_model();
        #2;
        rst = 1'b1;
        #1;
        check("init_out_valid", 64'(out_valid), 64'h0);
        check("init_cnt", 64'(cnt), 64'h0);
        check("init_sel", 64'(sel), 64'h0);
        check("init_in_ready", 64'(in_ready), 64'h0);
        check("init_out_data", 64'(out_data), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All channels enabled and ready: strict rotation, one per cycle
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'h10 + i), 4'hF, 4'hF);
            check("A_sel", 64'(sel), 64'(i % 4));
        end
        cycle(1'b0, 8'h00, 4'hF, 4'hF);
        for (int c = 0; c < 4; c++) check("A_cnt", 64'(dut_cnt(c)), 64'd2);

        // Only channels 1 and 3 enabled
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(8'h20 + i), 4'b1010, 4'hF);
            check("B_sel", 64'(sel), 64'(exp_b[i]));
        end
        cycle(1'b0, 8'h00, 4'b1010, 4'hF);
        check("B_cnt0", 64'(dut_cnt(0)), 64'd0);
        check("B_cnt1", 64'(dut_cnt(1)), 64'd2);
        check("B_cnt2", 64'(dut_cnt(2)), 64'd0);
        check("B_cnt3", 64'(dut_cnt(3)), 64'd2);

        // Stall on channel 2 while the others are ready
        cycle(1'b1, 8'hA5, 4'b0100, 4'hF);
        check("C_sel", 64'(sel), 64'd2);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'h33, 4'hF, 4'b1011);
            check("C_out_valid", 64'(out_valid), 64'b0100);
            check("C_in_ready", 64'(in_ready), 64'd0);
            check("C_cnt2", 64'(dut_cnt(2)), 64'd0);
        end
        cycle(1'b1, 8'h5A, 4'hF, 4'hF);
        check("C_cnt2_after", 64'(dut_cnt(2)), 64'd1);
        check("C_next_sel", 64'(sel), 64'd3);
        cycle(1'b0, 8'h00, 4'hF, 4'hF);

        // No channel enabled: nothing accepted
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h44, 4'b0000, 4'hF);
            check("D_out_valid", 64'(out_valid), 64'h0);
        end
        cycle(1'b1, 8'h45, 4'b0001, 4'hF);
        check("D_sel", 64'(sel), 64'd0);
        check("D_out_valid_full", 64'(out_valid), 64'b0001);
        cycle(1'b0, 8'h00, 4'hF, 4'hF);

        // Reset while holding an item on channel 1 with nonzero counters
        do_reset();
        cycle(1'b1, 8'h50, 4'hF, 4'hF);
        cycle(1'b1, 8'h51, 4'hF, 4'hF);
        cycle(1'b0, 8'h00, 4'hF, 4'h0);
        check("E_sel_before", 64'(sel), 64'd1);
        check("E_cnt0_before", 64'(dut_cnt(0)), 64'd1);
        do_reset();
        cycle(1'b1, 8'h52, 4'hF, 4'hF);
        check("E_sel_after", 64'(sel), 64'd0);
        cycle(1'b0, 8'h00, 4'hF, 4'hF);

        // Counter wrap on channel 0
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            cycle(1'b1, 8'(i), 4'b0001, 4'hF);
        end
        cycle(1'b0, 8'h00, 4'b0001, 4'hF);
        check("F_cnt0_wrap", 64'(dut_cnt(0)), 64'd1);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            r_en  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r_rdy = 4'($urandom);
            cycle($urandom_range(0, 3) != 0, 8'($urandom), r_en, r_rdy);
        end
        cycle(1'b0, 8'h00, 4'hF, 4'hF);
        cycle(1'b0, 8'h00, 4'hF, 4'hF);
        check("R_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
